// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, opcode encodings and fetch FSM type
package pipe_pkg;

    // Bubble instruction: sll $0,$0,0, an R-type write to $0 with no effect
    localparam logic [31:0] NOP_INST      = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP       = 32'h0000_0004;

    // Primary opcodes, inst[31:26]; shared by the ID decoder and branch/jump resolver
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, inst[5:0]
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // Fetch FSM: FETCH = last fetch completed, WAIT = imem inserting wait states
    typedef enum logic {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_e;

    // Sequential next PC, modulo 2^32
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

    // Word-align an address by clearing bits [1:0]
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, bubble and hold controls
module if_id_reg
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q,  pc4_d;
    logic        valid_q, valid_d;

    // Bubble has priority over load; with neither asserted the register holds
    always_comb begin
        inst_d  = inst_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (bubble_i) begin
            inst_d  = NOP_INST;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (load_i) begin
            inst_d  = inst_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    // Register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_q  <= NOP_INST;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign inst_o  = inst_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, next-PC mux, fetch FSM, bubble counter
module if_stage
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_ready,
    output logic [31:0]      if_id_inst,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             fetch_wait,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ifid_load;
    logic             ifid_bubble;
    logic             count_bubble;
    logic [31:0]      pc4;
    logic [31:0]      target_pc;

    // Low address bits of the redirect target are deliberately discarded
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

    assign pc4       = pc_plus4(pc_q);
    assign target_pc = word_align(redirect_pc);

    // Priority rules: redirect, then stall, then fetch completion, else wait state
    always_comb begin
        pc_d         = pc_q;
        state_d      = state_q;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        count_bubble = 1'b0;
        if (redirect) begin
            // Squash whatever is being fetched this cycle, even if imem is ready
            pc_d         = target_pc;
            ifid_bubble  = 1'b1;
            count_bubble = 1'b1;
            state_d      = FETCH;
        end else if (stall) begin
            // Full hold: PC, IF/ID and FSM keep their values
            pc_d    = pc_q;
            state_d = state_q;
        end else if (imem_ready) begin
            pc_d      = pc4;
            ifid_load = 1'b1;
            state_d   = FETCH;
        end else begin
            // Memory not ready: keep the address stable and feed ID a bubble
            ifid_bubble  = 1'b1;
            count_bubble = 1'b1;
            state_d      = WAIT;
        end
    end

    // Saturating bubble counter: stops at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (count_bubble && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // PC, FSM and counter registers; reset overrides every rule
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC_ALIGNED;
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .inst_i   (imem_rdata),
        .pc4_i    (pc4),
        .inst_o   (if_id_inst),
        .pc4_o    (if_id_pc4),
        .valid_o  (if_id_valid)
    );

    assign imem_addr  = pc_q;
    assign fetch_wait = (state_q == WAIT);
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    localparam int CNT_W = 3;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic             imem_ready;
    logic [31:0]      if_id_inst;
    logic [31:0]      if_id_pc4;
    logic             if_id_valid;
    logic             fetch_wait;
    logic [CNT_W-1:0] bubble_cnt;

    int total;
    int bad;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .if_id_inst  (if_id_inst),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .fetch_wait  (fetch_wait),
        .bubble_cnt  (bubble_cnt)
    );

    // Address-tagged instruction memory: word at A is ~A
    assign imem_rdata = ~imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle on the falling edge for checks/drive
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] addr,
                             input logic [31:0] inst, input logic [31:0] pc4,
                             input logic valid);
        chk({tag, ".addr"},  imem_addr, addr);
        chk({tag, ".inst"},  if_id_inst, inst);
        if (valid) chk({tag, ".pc4"}, if_id_pc4, pc4);
        chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, valid});
    endtask

    task automatic chk_cnt(input string tag, input int exp_cnt, input logic exp_wait);
        chk({tag, ".cnt"},  {29'b0, bubble_cnt}, 32'(exp_cnt));
        chk({tag, ".wait"}, {31'b0, fetch_wait}, {31'b0, exp_wait});
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b1;
        @(negedge clk);
        tick();
        tick();

        chk_fetch("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("reset.pc4", if_id_pc4, 32'h0);
        chk_cnt("reset", 0, 1'b0);

        // Free run from 0: eight fetches reach pc = 0x20
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk_fetch($sformatf("run%0d", k), 32'(4 * k), ~32'(4 * (k - 1)), 32'(4 * k), 1'b1);
        end
        chk_cnt("run", 0, 1'b0);

        // Redirect to 0x103 at pc 0x20: one bubble, then target at 0x100
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        chk_fetch("redir", 32'h100, 32'h0, 32'h0, 1'b0);
        chk_cnt("redir", 1, 1'b0);
        redirect = 1'b0;
        tick();
        chk_fetch("redir_tgt", 32'h104, ~32'h100, 32'h104, 1'b1);
        chk_cnt("redir_tgt", 1, 1'b0);

        // Three-cycle stall freezes everything
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_fetch($sformatf("stall%0d", k), 32'h104, ~32'h100, 32'h104, 1'b1);
        end
        stall = 1'b0;
        tick();
        chk_fetch("unstall", 32'h108, ~32'h104, 32'h108, 1'b1);
        chk_cnt("unstall", 1, 1'b0);

        // Two wait states, then the held instruction
        imem_ready = 1'b0;
        tick();
        chk_fetch("wait0", 32'h108, 32'h0, 32'h0, 1'b0);
        chk_cnt("wait0", 2, 1'b1);
        tick();
        chk_fetch("wait1", 32'h108, 32'h0, 32'h0, 1'b0);
        chk_cnt("wait1", 3, 1'b1);
        imem_ready = 1'b1;
        tick();
        chk_fetch("wait_done", 32'h10C, ~32'h108, 32'h10C, 1'b1);
        chk_cnt("wait_done", 3, 1'b0);

        // Stall with imem not ready: full hold, no bubble counted
        imem_ready = 1'b0;
        stall      = 1'b1;
        tick();
        chk_fetch("stall_nrdy", 32'h10C, ~32'h108, 32'h10C, 1'b1);
        chk_cnt("stall_nrdy", 3, 1'b0);

        // Redirect wins over stall
        imem_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        chk_fetch("redir_stall", 32'h200, 32'h0, 32'h0, 1'b0);
        chk_cnt("redir_stall", 4, 1'b0);
        redirect = 1'b0;
        stall    = 1'b0;
        tick();
        chk_fetch("redir_stall_tgt", 32'h204, ~32'h200, 32'h204, 1'b1);

        // Redirect during WAIT returns to FETCH at the target
        imem_ready = 1'b0;
        tick();
        chk_cnt("pre_redir_wait", 5, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFA;
        tick();
        chk_fetch("redir_wait", 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b0);
        chk_cnt("redir_wait", 6, 1'b0);
        redirect   = 1'b0;
        imem_ready = 1'b1;
        tick();
        chk_fetch("near_top", 32'hFFFF_FFFC, ~32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1);

        // PC wraps from 0xFFFF_FFFC to 0
        tick();
        chk_fetch("wrap", 32'h0, ~32'hFFFF_FFFC, 32'h0, 1'b1);
        tick();
        chk_fetch("post_wrap", 32'h4, ~32'h0, 32'h4, 1'b1);

        // Counter saturates at all-ones (7 for a 3-bit counter)
        imem_ready = 1'b0;
        tick();
        chk_cnt("sat0", 7, 1'b1);
        tick();
        chk_cnt("sat1", 7, 1'b1);
        tick();
        chk_cnt("sat2", 7, 1'b1);
        chk("sat.addr", imem_addr, 32'h4);

        // Reset during WAIT with a redirect pending: reset wins
        rst_n       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0400;
        tick();
        chk_fetch("rst_wait", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rst_wait.pc4", if_id_pc4, 32'h0);
        chk_cnt("rst_wait", 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the bench always terminates
    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
